// File: rtl/audio_pkg.sv
// Shared types and constants for the sigma-delta decimator.
package audio_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } dec_state_e;

    localparam int unsigned OVF_CNT_WIDTH = 8;

    // Saturating increment for the overrun event counter
    function automatic logic [OVF_CNT_WIDTH-1:0] ovf_cnt_inc(input logic [OVF_CNT_WIDTH-1:0] cnt);
        logic [OVF_CNT_WIDTH-1:0] nxt;
        nxt = cnt;
        if (cnt != {OVF_CNT_WIDTH{1'b1}}) begin
            nxt = cnt + OVF_CNT_WIDTH'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sigma_delta_window_acc.sv
// Window accumulator: counts 2^CODE_WIDTH pdm samples, sums the ones and
// produces the saturated window result on the final sample.
module sigma_delta_window_acc #(
    parameter int unsigned CODE_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  sample_i,
    input  logic                  pdm_i,
    output logic                  done_c_o,
    output logic [CODE_WIDTH-1:0] result_c_o
);

    localparam int unsigned ONES_WIDTH = CODE_WIDTH + 1;

    logic [CODE_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
    logic [ONES_WIDTH-1:0] ones_q, ones_d;
    logic [ONES_WIDTH-1:0] ones_sum_c;
    logic                  last_sample_c;

    // Running sum including the current sample; tops out at exactly 2^CODE_WIDTH
    always_comb begin
        ones_sum_c    = ones_q + ONES_WIDTH'(pdm_i);
        last_sample_c = sample_i && (sample_cnt_q == {CODE_WIDTH{1'b1}});
    end

    always_comb begin
        result_c_o = ones_sum_c[CODE_WIDTH-1:0];
        if (ones_sum_c[CODE_WIDTH]) begin
            result_c_o = {CODE_WIDTH{1'b1}};
        end
        done_c_o = last_sample_c;
    end

    // The last sample wraps both counters so the next window starts immediately
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        ones_d       = ones_q;
        if (clear_i) begin
            sample_cnt_d = '0;
            ones_d       = '0;
        end else if (sample_i) begin
            if (last_sample_c) begin
                sample_cnt_d = '0;
                ones_d       = '0;
            end else begin
                sample_cnt_d = sample_cnt_q + CODE_WIDTH'(1);
                ones_d       = ones_sum_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_q <= '0;
            ones_q       <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            ones_q       <= ones_d;
        end
    end

endmodule

// File: rtl/sigma_delta_decimator.sv
// Sigma-delta decimator: IDLE/ACCUM control, result register with valid/ready
// handshake and sticky overrun flag. Optional overrun event counter is enabled
// by defining SIGMA_DELTA_DECIMATOR_OVF_CNT_EN.
module sigma_delta_decimator
    import audio_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pdm,
    input  logic                     pdm_valid,
    output logic [CODE_WIDTH-1:0]    code,
    output logic                     code_valid,
    input  logic                     code_ready,
    output logic                     overrun,
    input  logic                     overrun_clr
`ifdef SIGMA_DELTA_DECIMATOR_OVF_CNT_EN
    ,
    output logic [OVF_CNT_WIDTH-1:0] overrun_count
`endif
);

    dec_state_e            state_q, state_d;
    logic                  accum_c;
    logic                  load_c;
    logic [CODE_WIDTH-1:0] result_c;
    logic                  consume_c;
    logic                  overrun_evt_c;

    logic [CODE_WIDTH-1:0] code_q, code_d;
    logic                  code_valid_q, code_valid_d;
    logic                  overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable)  state_d = ST_ACCUM;
            ST_ACCUM: if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accum_c = 1'b0;
        if (state_q == ST_ACCUM) begin
            accum_c = 1'b1;
        end
    end

    // Counters are held clear outside ACCUM, which also drops any partial window
    sigma_delta_window_acc #(
        .CODE_WIDTH (CODE_WIDTH)
    ) u_window_acc (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (!accum_c),
        .sample_i   (accum_c && pdm_valid),
        .pdm_i      (pdm),
        .done_c_o   (load_c),
        .result_c_o (result_c)
    );

    always_comb begin
        consume_c     = code_valid_q && code_ready;
        overrun_evt_c = load_c && code_valid_q && !code_ready;
    end

    // A new load always wins over consumption; overrun set wins over clear
    always_comb begin
        code_d       = code_q;
        code_valid_d = code_valid_q;
        overrun_d    = overrun_q;
        if (load_c) begin
            code_d       = result_c;
            code_valid_d = 1'b1;
        end else if (consume_c) begin
            code_valid_d = 1'b0;
        end
        if (overrun_evt_c) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q       <= '0;
            code_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign overrun    = overrun_q;

`ifdef SIGMA_DELTA_DECIMATOR_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    // Clear applies first so a same-cycle event still counts once
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (overrun_clr) begin
            ovf_cnt_d = '0;
        end
        if (overrun_evt_c) begin
            ovf_cnt_d = ovf_cnt_inc(ovf_cnt_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign overrun_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: CODE_WIDTH=4 and CODE_WIDTH=10 instances share
// one input stream and are checked against a window-level reference model.
module tb_sigma_delta_decimator;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, pdm, pdm_valid, code_ready, overrun_clr;
    logic [3:0] code4;
    logic       cv4, ov4;
    logic [9:0] code10;
    logic       cv10, ov10;
`ifdef SIGMA_DELTA_DECIMATOR_OVF_CNT_EN
    logic [7:0] ovc4, ovc10;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = 16-sample window, 1 = 1024-sample window
    int m_cnt [2];
    int m_ones[2];
    int m_code[2];
    int m_ovc [2];
    bit m_valid[2];
    bit m_ovr [2];
    bit m_accum;

    always #5 clk = ~clk;

    sigma_delta_decimator #(.CODE_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .pdm(pdm), .pdm_valid(pdm_valid),
        .code(code4), .code_valid(cv4), .code_ready(code_ready),
        .overrun(ov4), .overrun_clr(overrun_clr)
`ifdef SIGMA_DELTA_DECIMATOR_OVF_CNT_EN
        , .overrun_count(ovc4)
`endif
    );

    sigma_delta_decimator #(.CODE_WIDTH(10)) dut10 (
        .clk(clk), .rst(rst), .enable(enable), .pdm(pdm), .pdm_valid(pdm_valid),
        .code(code10), .code_valid(cv10), .code_ready(code_ready),
        .overrun(ov10), .overrun_clr(overrun_clr)
`ifdef SIGMA_DELTA_DECIMATOR_OVF_CNT_EN
        , .overrun_count(ovc10)
`endif
    );

    function automatic int win_len(input int d);
        return (d == 0) ? 16 : 1024;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_ones[d] = 0; m_code[d] = 0; m_ovc[d] = 0;
            m_valid[d] = 1'b0; m_ovr[d] = 1'b0;
        end
        m_accum = 1'b0;
    endtask

    // One rising edge of the specified behaviour, using the inputs currently driven
    task automatic model_edge();
        bit load, evt;
        int res;
        for (int d = 0; d < 2; d++) begin
            load = 1'b0;
            res  = 0;
            if (!m_accum) begin
                m_cnt[d]  = 0;
                m_ones[d] = 0;
            end else if (pdm_valid) begin
                m_cnt[d]++;
                m_ones[d] += int'(pdm);
                if (m_cnt[d] == win_len(d)) begin
                    load = 1'b1;
                    res  = (m_ones[d] > win_len(d) - 1) ? win_len(d) - 1 : m_ones[d];
                    m_cnt[d]  = 0;
                    m_ones[d] = 0;
                end
            end
            evt = load && m_valid[d] && !code_ready;
            if (load) begin
                m_code[d]  = res;
                m_valid[d] = 1'b1;
            end else if (m_valid[d] && code_ready) begin
                m_valid[d] = 1'b0;
            end
            if (overrun_clr) m_ovc[d] = 0;
            if (evt && m_ovc[d] < 255) m_ovc[d]++;
            if (evt) m_ovr[d] = 1'b1;
            else if (overrun_clr) m_ovr[d] = 1'b0;
        end
        m_accum = enable;
    endtask

    task automatic check_all();
        chk("code4",   32'(code4),  32'(m_code[0]));
        chk("valid4",  32'(cv4),    32'(m_valid[0]));
        chk("ovr4",    32'(ov4),    32'(m_ovr[0]));
        chk("code10",  32'(code10), 32'(m_code[1]));
        chk("valid10", 32'(cv10),   32'(m_valid[1]));
        chk("ovr10",   32'(ov10),   32'(m_ovr[1]));
`ifdef SIGMA_DELTA_DECIMATOR_OVF_CNT_EN
        chk("ovc4",    32'(ovc4),   32'(m_ovc[0]));
        chk("ovc10",   32'(ovc10),  32'(m_ovc[1]));
`endif
    endtask

    task automatic step(input bit en, input bit p, input bit pv, input bit rdy, input bit clr);
        enable      = en;
        pdm         = p;
        pdm_valid   = pv;
        code_ready  = rdy;
        overrun_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int ones2, exp2, vcnt, dac_acc, dac_sum;
        bit p;

        rst = 1'b0; enable = 1'b0; pdm = 1'b0; pdm_valid = 1'b0;
        code_ready = 1'b0; overrun_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_code4", 32'(code4), 0);
        chk("rst_valid4", 32'(cv4), 0);
        chk("rst_ovr4", 32'(ov4), 0);
        chk("rst_code10", 32'(code10), 0);
        chk("rst_valid10", 32'(cv10), 0);
        chk("rst_ovr10", 32'(ov10), 0);

        // All-ones stream: full-scale saturates to 15 every 16 samples
        step(1, 1, 1, 1, 0);
        for (int i = 1; i <= 40; i++) begin
            step(1, 1, 1, 1, 0);
            if (i == 15) chk("t27_valid_early", 32'(cv4), 0);
            if (i == 16) begin
                chk("t27_valid", 32'(cv4), 1);
                chk("t27_code", 32'(code4), 15);
            end
        end

        // Alternating samples, valid every third cycle
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        vcnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (i % 3 == 2) begin
                p = (vcnt % 2 == 0);
                vcnt++;
                step(1, p, 1, 1, 0);
            end else begin
                step(1, 0, 0, 1, 0);
            end
            if (i == 46) chk("t28_valid_early", 32'(cv4), 0);
        end
        chk("t28_valid", 32'(cv4), 1);
        chk("t28_code", 32'(code4), 8);

        // Two windows with no consumer: second result overwrites and flags overrun
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        ones2 = 0;
        for (int i = 1; i <= 32; i++) begin
            p = 1'($urandom_range(0, 1));
            if (i > 16) ones2 += int'(p);
            step(1, p, 1, 0, 0);
            if (i == 16) begin
                chk("t30_valid1", 32'(cv4), 1);
                chk("t30_ovr1", 32'(ov4), 0);
            end
        end
        exp2 = (ones2 > 15) ? 15 : ones2;
        chk("t30_ovr2", 32'(ov4), 1);
        chk("t30_code2", 32'(code4), 32'(exp2));
        step(1, 0, 0, 0, 1);
        chk("t30_clr", 32'(ov4), 0);

        // Enable dropped mid-window: partial window lost, held result untouched
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("t31_hold_code", 32'(code4), 32'(exp2));
            chk("t31_hold_valid", 32'(cv4), 1);
        end
        step(1, 1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1, 1, 1, 0, 0);
            if (i == 15) chk("t31_code_early", 32'(code4), 32'(exp2));
        end
        chk("t31_code", 32'(code4), 15);
        chk("t31_ovr", 32'(ov4), 1);
        step(1, 0, 0, 1, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-window with live outputs
        for (int i = 0; i < 40; i++) step(1, 1, 1, 0, 0);
        chk("t32_pre_valid", 32'(cv4), 1);
        chk("t32_pre_ovr", 32'(ov4), 1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("t32_code4", 32'(code4), 0);
        chk("t32_valid4", 32'(cv4), 0);
        chk("t32_ovr4", 32'(ov4), 0);
        chk("t32_code10", 32'(code10), 0);
        chk("t32_valid10", 32'(cv10), 0);
        chk("t32_ovr10", 32'(ov10), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        chk("t32_held_valid4", 32'(cv4), 0);
        step(1, 1, 1, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1, 1, 1, 1, 0);
            if (i == 15) chk("t32_post_early", 32'(cv4), 0);
        end
        chk("t32_post_valid", 32'(cv4), 1);
        chk("t32_post_code", 32'(code4), 15);

        // First-order DAC loopback at code 300 into the 10-bit instance
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);
        dac_acc = 0;
        for (int i = 0; i < 3 * 1024 + 1; i++) begin
            dac_sum = dac_acc + 300;
            p       = (dac_sum >= 1024);
            dac_acc = dac_sum % 1024;
            step(1, p, 1, 1, 0);
            if (m_valid[1]) begin
                chk("t29_code", 32'(code10), 300);
                chk("t29_ovr", 32'(ov10), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
